// File: rtl/axi4lite_protocol_monitor.sv
// rtl/axi4lite_protocol_monitor.sv - passive AXI4-Lite protocol checker with sticky error status
//
// Observes one AXI4-Lite link and records rule violations in err_status.
// Bits: 0 AR stable, 1 AW stable, 2 W stable, 3 R stable, 4 B stable,
//       5 R without outstanding read, 6 B without outstanding AW/W,
//       7 EXOKAY response, 8 outstanding overflow, 9 VALID right after reset,
//       10 read timeout, 11 write timeout.
// Optional watchdog (bits 10/11) compiled in with `define AXI4LITE_MON_TIMEOUT_EN.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN (sync active-low) : clock / reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*, S_AXI_AR*, S_AXI_R* : observed bus (inputs only)
//   clr             : clears err_status, first_err, first_err_valid
//   err_status      : sticky violation bits
//   err_pulse       : one cycle high when a new violation bit is recorded
//   first_err       : index of first violation since clear
//   first_err_valid : first_err is meaningful
//   rd_outstanding  : accepted AR not yet answered
//   wr_outstanding  : min(aw_cnt, w_cnt)

module axi4lite_protocol_monitor #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    input  logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    input  logic                    S_AXI_WREADY,
    input  logic [1:0]              S_AXI_BRESP,
    input  logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    input  logic                    S_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    input  logic [1:0]              S_AXI_RRESP,
    input  logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    input  logic                    clr,
    output logic [11:0]             err_status,
    output logic                    err_pulse,
    output logic [3:0]              first_err,
    output logic                    first_err_valid,
    output logic [CNT_W-1:0]        rd_outstanding,
    output logic [CNT_W-1:0]        wr_outstanding
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;
    assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;

    // Stability tracking: pend = VALID && !READY last cycle, plus payload copy.
    logic                    ar_pend, aw_pend, w_pend, r_pend, b_pend;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, aw_addr_q;
    logic [2:0]              ar_prot_q, aw_prot_q;
    logic [DATA_WIDTH-1:0]   w_data_q, r_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;
    logic [1:0]              r_resp_q, b_resp_q;

    logic [CNT_W-1:0] rd_cnt, aw_cnt, w_cnt;
    logic             rst_seen;   // previous edge was in reset
    logic [11:0]      viol;
    logic [1:0]       wd_viol;
    logic [3:0]       viol_idx;

    assign rd_outstanding = rd_cnt;
    assign wr_outstanding = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;

    always_comb begin
        viol    = 12'h000;
        viol[0] = ar_pend && (!S_AXI_ARVALID || S_AXI_ARADDR != ar_addr_q || S_AXI_ARPROT != ar_prot_q);
        viol[1] = aw_pend && (!S_AXI_AWVALID || S_AXI_AWADDR != aw_addr_q || S_AXI_AWPROT != aw_prot_q);
        viol[2] = w_pend  && (!S_AXI_WVALID  || S_AXI_WDATA  != w_data_q  || S_AXI_WSTRB  != w_strb_q);
        viol[3] = r_pend  && (!S_AXI_RVALID  || S_AXI_RDATA  != r_data_q  || S_AXI_RRESP  != r_resp_q);
        viol[4] = b_pend  && (!S_AXI_BVALID  || S_AXI_BRESP  != b_resp_q);
        viol[5] = S_AXI_RVALID && (rd_cnt == '0);
        viol[6] = S_AXI_BVALID && (aw_cnt == '0 || w_cnt == '0);
        viol[7] = (S_AXI_RVALID && S_AXI_RRESP == 2'b01) || (S_AXI_BVALID && S_AXI_BRESP == 2'b01);
        // Only a net increment can overflow; a simultaneous decrement cancels it.
        viol[8] = (ar_hs && !r_hs && rd_cnt == CNT_MAX) ||
                  (aw_hs && !b_hs && aw_cnt == CNT_MAX) ||
                  (w_hs  && !b_hs && w_cnt  == CNT_MAX);
        viol[9] = rst_seen && (S_AXI_ARVALID || S_AXI_AWVALID || S_AXI_WVALID ||
                               S_AXI_RVALID  || S_AXI_BVALID);
        viol[11:10] = wd_viol;
    end

    // Lowest set index wins when several checks fire in the same cycle.
    always_comb begin
        viol_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (viol[i]) viol_idx = 4'(i);
        end
    end

    // Saturating up/down counter step.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = cnt;
        if (inc && !dec && cnt != CNT_MAX) r = cnt + 1'b1;
        else if (dec && !inc && cnt != '0) r = cnt - 1'b1;
        return r;
    endfunction

`ifdef AXI4LITE_MON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
    logic [TO_W-1:0] rd_wd, wr_wd;
    logic            rd_wait, wr_wait;

    assign rd_wait = (rd_cnt != '0) && !r_hs;
    assign wr_wait = (wr_outstanding != '0) && !b_hs;
    // Flag on the edge where the counter reaches the limit; it then holds there.
    assign wd_viol[0] = rd_wait && (rd_wd == TO_LIM - 1'b1);
    assign wd_viol[1] = wr_wait && (wr_wd == TO_LIM - 1'b1);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rd_wd <= '0;
            wr_wd <= '0;
        end else begin
            if (!rd_wait)             rd_wd <= '0;
            else if (rd_wd != TO_LIM) rd_wd <= rd_wd + 1'b1;
            if (!wr_wait)             wr_wd <= '0;
            else if (wr_wd != TO_LIM) wr_wd <= wr_wd + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
    assign wd_viol = 2'b00;
`endif

    logic [11:0] status_base;
    logic        fv_base;
    assign status_base = clr ? 12'h000 : err_status;
    assign fv_base     = clr ? 1'b0 : first_err_valid;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            err_status      <= '0;
            err_pulse       <= 1'b0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            rd_cnt          <= '0;
            aw_cnt          <= '0;
            w_cnt           <= '0;
            rst_seen        <= 1'b1;
            ar_pend         <= 1'b0;
            aw_pend         <= 1'b0;
            w_pend          <= 1'b0;
            r_pend          <= 1'b0;
            b_pend          <= 1'b0;
        end else begin
            rst_seen   <= 1'b0;
            // Clear is applied before set, so a violation in the clr cycle survives.
            err_status <= status_base | viol;
            err_pulse  <= |(viol & ~status_base);
            if (!fv_base && |viol) begin
                first_err       <= viol_idx;
                first_err_valid <= 1'b1;
            end else if (clr) begin
                first_err       <= '0;
                first_err_valid <= 1'b0;
            end

            rd_cnt <= cnt_step(rd_cnt, ar_hs, r_hs);
            aw_cnt <= cnt_step(aw_cnt, aw_hs, b_hs);
            w_cnt  <= cnt_step(w_cnt,  w_hs,  b_hs);

            ar_pend <= S_AXI_ARVALID && !S_AXI_ARREADY;
            aw_pend <= S_AXI_AWVALID && !S_AXI_AWREADY;
            w_pend  <= S_AXI_WVALID  && !S_AXI_WREADY;
            r_pend  <= S_AXI_RVALID  && !S_AXI_RREADY;
            b_pend  <= S_AXI_BVALID  && !S_AXI_BREADY;
        end
    end

    // Payload copies need no reset; they are only read while pend is set.
    always_ff @(posedge S_AXI_ACLK) begin
        ar_addr_q <= S_AXI_ARADDR;
        ar_prot_q <= S_AXI_ARPROT;
        aw_addr_q <= S_AXI_AWADDR;
        aw_prot_q <= S_AXI_AWPROT;
        w_data_q  <= S_AXI_WDATA;
        w_strb_q  <= S_AXI_WSTRB;
        r_data_q  <= S_AXI_RDATA;
        r_resp_q  <= S_AXI_RRESP;
        b_resp_q  <= S_AXI_BRESP;
    end

endmodule

// File: tb/tb_axi4lite_protocol_monitor.sv
// tb/tb_axi4lite_protocol_monitor.sv - directed self-checking bench for axi4lite_protocol_monitor

module tb_axi4lite_protocol_monitor;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        clr;
    logic [11:0] err_status;
    logic        err_pulse;
    logic [3:0]  first_err;
    logic        first_err_valid;
    logic [1:0]  rd_outstanding, wr_outstanding;

    int total = 0;
    int bad   = 0;
    logic exp_to;

    always #5 clk = ~clk;

    axi4lite_protocol_monitor #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .clr(clr), .err_status(err_status), .err_pulse(err_pulse), .first_err(first_err),
        .first_err_valid(first_err_valid), .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; rvalid = 0; rready = 0; clr = 0;
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        wdata = 0; rdata = 0; wstrb = 4'hF; bresp = 0; rresp = 0;
    endtask

    task automatic do_clr();
        clr = 1; tick(); clr = 0;
    endtask

    initial begin
        idle();
        resetn = 0;
        tick(); tick();
        check("rst_status", 32'(err_status), 32'h000);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_fev", 32'(first_err_valid), 0);
        check("rst_rd", 32'(rd_outstanding), 0);
        check("rst_wr", 32'(wr_outstanding), 0);
        resetn = 1; tick();
        check("release_idle", 32'(err_status), 32'h000);

        // AR payload changes while stalled
        arvalid = 1; araddr = 4'h4; tick();
        check("ar_hold_ok", 32'(err_status), 32'h000);
        araddr = 4'h8; tick();
        check("ar_stab_status", 32'(err_status), 32'h001);
        check("ar_stab_pulse", 32'(err_pulse), 1);
        check("ar_stab_first", 32'(first_err), 0);
        check("ar_stab_fev", 32'(first_err_valid), 1);
        tick();
        check("ar_pulse_drop", 32'(err_pulse), 0);
        arready = 1; tick();
        check("ar_hs_rd", 32'(rd_outstanding), 1);
        arvalid = 0; arready = 0; rvalid = 1; rready = 1; tick();
        rvalid = 0; rready = 0;
        check("ar_r_rd", 32'(rd_outstanding), 0);
        check("ar_r_status", 32'(err_status), 32'h001);
        do_clr();
        check("clr_status", 32'(err_status), 32'h000);
        check("clr_fev", 32'(first_err_valid), 0);

        // R with nothing outstanding, then EXOKAY
        rvalid = 1; rready = 1; tick();
        rvalid = 0; rready = 0;
        check("r_noar_status", 32'(err_status), 32'h020);
        check("r_noar_first", 32'(first_err), 5);
        check("r_noar_rd", 32'(rd_outstanding), 0);
        arvalid = 1; arready = 1; tick();
        arvalid = 0; arready = 0; rvalid = 1; rready = 1; rresp = 2'b01; tick();
        rvalid = 0; rready = 0; rresp = 0;
        check("exok_status", 32'(err_status), 32'h0A0);
        check("exok_first", 32'(first_err), 5);
        do_clr();

        // Overflow at MAX_OUTSTANDING = 2, then drain past zero
        arvalid = 1; arready = 1;
        tick(); tick();
        check("ovf_pre", 32'(err_status), 32'h000);
        tick();
        arvalid = 0; arready = 0;
        check("ovf_rd", 32'(rd_outstanding), 2);
        check("ovf_status", 32'(err_status), 32'h100);
        rvalid = 1; rready = 1;
        tick();
        check("drain1_rd", 32'(rd_outstanding), 1);
        tick();
        check("drain2_status", 32'(err_status), 32'h100);
        tick();
        rvalid = 0; rready = 0;
        check("drain3_rd", 32'(rd_outstanding), 0);
        check("drain3_status", 32'(err_status), 32'h120);
        do_clr();

        // B before W, then W and B
        awvalid = 1; awready = 1; tick();
        awvalid = 0; awready = 0;
        check("aw_only_wr", 32'(wr_outstanding), 0);
        bvalid = 1; bready = 1; tick();
        bvalid = 0; bready = 0;
        check("b_early_status", 32'(err_status), 32'h040);
        check("b_early_first", 32'(first_err), 6);
        wvalid = 1; wready = 1; tick();
        wvalid = 0; wready = 0;
        bvalid = 1; bready = 1; tick();
        bvalid = 0; bready = 0;
        check("b_late_status", 32'(err_status), 32'h040);
        check("b_late_wr", 32'(wr_outstanding), 0);

        // VALID at reset release, then clr together with W instability
        resetn = 0; awvalid = 1; tick();
        check("mid_rst_status", 32'(err_status), 32'h000);
        resetn = 1; tick();
        check("rel_valid_status", 32'(err_status), 32'h200);
        check("rel_valid_first", 32'(first_err), 9);
        awready = 1; tick();
        awvalid = 0; awready = 0;
        wvalid = 1; wdata = 32'hAAAA_AAAA; tick();
        wdata = 32'hBBBB_BBBB; clr = 1; tick();
        clr = 0;
        check("clr_set_status", 32'(err_status), 32'h004);
        check("clr_set_first", 32'(first_err), 2);
        check("clr_set_fev", 32'(first_err_valid), 1);
        wready = 1; tick();
        wvalid = 0; wready = 0;
        check("wb_wr", 32'(wr_outstanding), 1);
        bvalid = 1; bready = 1; tick();
        bvalid = 0; bready = 0;
        check("wb_done_wr", 32'(wr_outstanding), 0);
        check("wb_done_status", 32'(err_status), 32'h004);
        do_clr();

        // Read watchdog: handshake edge, then 8 edges without R
`ifdef AXI4LITE_MON_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        arvalid = 1; arready = 1; tick();
        arvalid = 0; arready = 0;
        for (int i = 0; i < 7; i++) tick();
        check("to_before", 32'(err_status[10]), 0);
        check("to_rd", 32'(rd_outstanding), 1);
        tick();
        check("to_at8", 32'(err_status[10]), 32'(exp_to));
        rvalid = 1; rready = 1; tick();
        rvalid = 0; rready = 0;
        check("to_end_rd", 32'(rd_outstanding), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
